dircc_compute_scheduler: RTL and testbench

//  Sequences the per-thread compute handler over all THREAD_COUNT thread contexts held in the

---
 rtl/dircc_compute_scheduler_if.sv | 31 +++
 rtl/dircc_compute_scheduler.sv | 148 ++++++++++++++
 tb/tb_dircc_compute_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dircc_compute_scheduler_if.sv
// Bus bundle between the compute scheduler, the device state memory port and the compute handler.
// The scheduler drives the master modport; the memory/handler side uses the slave modport.
interface dircc_compute_scheduler_if #(
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int STATE_WIDTH       = 128
);
    logic [ADDRESS_MEM_WIDTH-1:0] mem_address;
    logic                         mem_read;
    logic                         mem_write;
    logic [STATE_WIDTH-1:0]       mem_writedata;
    logic [STATE_WIDTH-1:0]       mem_readdata;
    logic                         mem_waitrequest;
    logic [ADDRESS_MEM_WIDTH-1:0] compute_address;
    logic [STATE_WIDTH-1:0]       compute_read_state;
    logic [STATE_WIDTH-1:0]       compute_write_state;
    logic                         compute_valid;

    modport master (
        output mem_address, mem_read, mem_write, mem_writedata,
        output compute_address, compute_read_state,
        input  mem_readdata, mem_waitrequest,
        input  compute_write_state, compute_valid
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata,
        input  compute_address, compute_read_state,
        output mem_readdata, mem_waitrequest,
        output compute_write_state, compute_valid
    );
endinterface

// File: rtl/dircc_compute_scheduler.sv
// Round-robin sweep of the compute handler over all thread contexts in the device state memory.
// Optional DIRCC_SCHED_STATS_EN adds saturating update_count / sweep_count outputs.
module dircc_compute_scheduler #(
    parameter int THREAD_COUNT      = 4,
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int STATE_WIDTH       = 128,
    parameter int READ_LATENCY      = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    dircc_compute_scheduler_if.master   bus,
    output logic                        sweep_done,
    output logic                        active
`ifdef DIRCC_SCHED_STATS_EN
    ,
    output logic [31:0]                 update_count,
    output logic [31:0]                 sweep_count
`endif
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);
    localparam logic [ADDRESS_MEM_WIDTH-1:0] LAST_IDX = ADDRESS_MEM_WIDTH'(THREAD_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_COMPUTE,
        S_EVAL,
        S_WR,
        S_NEXT
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [ADDRESS_MEM_WIDTH-1:0] index;
    logic [LAT_W-1:0]             lat_cnt;
    logic [STATE_WIDTH-1:0]       state_q;
    logic [STATE_WIDTH-1:0]       wr_data_q;
    logic                         rd_req;
    logic                         wr_req;
    logic                         wrap;

    assign wrap = (index == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enable is only consulted between threads, so a thread always finishes its write-back.
    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_RD_REQ;
            end
            S_RD_REQ: begin
                rd_req = 1'b1;
                if (!bus.mem_waitrequest) state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_cnt == LAT_LAST) state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                state_nxt = S_EVAL;
            end
            S_EVAL: begin
                state_nxt = bus.compute_valid ? S_WR : S_NEXT;
            end
            S_WR: begin
                wr_req = 1'b1;
                if (!bus.mem_waitrequest) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                state_nxt = enable ? S_RD_REQ : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Read data is valid on the READ_LATENCY-th cycle after the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index     <= '0;
            lat_cnt   <= '0;
            state_q   <= '0;
            wr_data_q <= '0;
        end else begin
            case (state)
                S_RD_REQ: begin
                    if (!bus.mem_waitrequest) lat_cnt <= LAT_INIT;
                end
                S_RD_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state_q <= bus.mem_readdata;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_EVAL: begin
                    if (bus.compute_valid) wr_data_q <= bus.compute_write_state;
                end
                S_NEXT: begin
                    index <= wrap ? '0 : index + ADDRESS_MEM_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_address        = index;
    assign bus.mem_read           = rd_req;
    assign bus.mem_write          = wr_req;
    assign bus.mem_writedata      = wr_data_q;
    assign bus.compute_address    = index;
    assign bus.compute_read_state = state_q;
    assign sweep_done             = (state == S_NEXT) && wrap;
    assign active                 = (state != S_IDLE);

`ifdef DIRCC_SCHED_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update_count <= '0;
            sweep_count  <= '0;
        end else begin
            if ((state == S_WR) && !bus.mem_waitrequest) update_count <= sat_inc(update_count);
            if (sweep_done) sweep_count <= sat_inc(sweep_count);
        end
    end
`endif

endmodule

// File: tb/tb_dircc_compute_scheduler.sv
// Randomized bench for dircc_compute_scheduler: the bench plays memory and compute handler and
// checks the transaction stream against a thread-by-thread model of the sweep.
module tb_dircc_compute_scheduler;

    localparam int TC = 4;
    localparam int AW = 32;
    localparam int SW = 128;

    logic clk;
    logic reset;
    logic enable;
    logic sweep_done;
    logic active;
`ifdef DIRCC_SCHED_STATS_EN
    logic [31:0] update_count;
    logic [31:0] sweep_count;
`endif

    dircc_compute_scheduler_if #(.ADDRESS_MEM_WIDTH(AW), .STATE_WIDTH(SW)) bus ();

    dircc_compute_scheduler #(
        .THREAD_COUNT(TC), .ADDRESS_MEM_WIDTH(AW), .STATE_WIDTH(SW), .READ_LATENCY(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .bus(bus),
        .sweep_done(sweep_done),
        .active(active)
`ifdef DIRCC_SCHED_STATS_EN
        ,
        .update_count(update_count),
        .sweep_count(sweep_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handler behaviour: mode 0 data-dependent, 1 always valid, 2 valid except thread 2.
    function automatic logic hv(input int mode, input logic [31:0] addr, input logic [127:0] s);
        case (mode)
            1:       return 1'b1;
            2:       return addr != 32'd2;
            default: return s[0] ^ s[9];
        endcase
    endfunction

    function automatic logic [127:0] hg(input logic [127:0] s);
        return {s[119:0], s[127:120]} ^ {4{32'hA5C3_0F1E}};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    int vmode = 1;
    int wmode = 0;

    logic [127:0] mem_m [TC];
    int           cyc = 0;
    int           rd_count = 0;
    int           wr_count = 0;
    int           sweep_cnt = 0;
    int           stat_wr = 0;
    int           stat_sw = 0;
    int           last_rd_cyc = 0;
    int           stalls = 0;
    int           st_cnt = 0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wr_addr = '0;
    logic [31:0]  exp_idx = '0;
    logic [31:0]  cur_idx = '0;
    bit           exp_wr_pend = 0;
    bit           have_prev = 0;
    bit           en_stable = 0;
    bit           saw_sweep = 0;
    bit           prev_stall = 0;
    bit           wrote = 0;
    logic [127:0] exp_wr_data = '0;
    logic [255:0] prev_req = '0;
    logic [255:0] cur_req;
    logic         wreq;
    logic         pv;
    logic [127:0] pws;
    logic [127:0] prd;

    // Memory + handler model and scoreboard: sample at negedge, drive just after posedge.
    initial begin
        bus.mem_waitrequest     = 1'b0;
        bus.mem_readdata        = '0;
        bus.compute_valid       = 1'b0;
        bus.compute_write_state = '0;
        forever begin
            @(negedge clk);
            cyc++;
            wreq = 1'b0;
            if (wmode == 1) wreq = ($urandom_range(0, 3) == 0);
            else if (wmode == 2) wreq = (bus.mem_read && st_cnt < 3) || (bus.mem_write && st_cnt < 2);
            bus.mem_waitrequest = wreq;
            prd = rand128();
            if (reset) begin
                exp_idx = '0; exp_wr_pend = 0; have_prev = 0; saw_sweep = 0;
                prev_stall = 0; st_cnt = 0; en_stable = 0; stalls = 0; wrote = 0;
                stat_wr = 0; stat_sw = 0;
            end else begin
                if (bus.mem_read || bus.mem_write)
                    check_eq("rw_exclusive", bus.mem_read && bus.mem_write, 0);
                cur_req = {bus.mem_read, bus.mem_write, bus.mem_address,
                           bus.mem_write ? bus.mem_writedata : 128'd0};
                if (prev_stall) check_eq("req_hold", cur_req, prev_req);
                prev_req   = cur_req;
                prev_stall = (bus.mem_read || bus.mem_write) && wreq;
                if (prev_stall) begin
                    stalls++;
                    st_cnt++;
                end else begin
                    st_cnt = 0;
                end
                if (!enable) en_stable = 0;
                if (sweep_done) begin
                    check_eq("sweep_idx", last_rd_addr, TC - 1);
                    check_eq("sweep_dup", saw_sweep, 0);
                    check_eq("sweep_before_wr", exp_wr_pend, 0);
                    saw_sweep = 1;
                    sweep_cnt++;
                    stat_sw++;
                end
                if (bus.mem_read && !wreq) begin
                    check_eq("rd_addr", bus.mem_address, exp_idx);
                    check_eq("rd_missing_wr", exp_wr_pend, 0);
                    if (exp_idx == 0 && have_prev) begin
                        check_eq("sweep_pulse", saw_sweep, 1);
                        saw_sweep = 0;
                    end
                    if (have_prev && en_stable)
                        check_eq("thread_gap", cyc - last_rd_cyc, 5 + int'(wrote) + stalls);
                    if (bus.mem_address < TC) prd = mem_m[bus.mem_address[1:0]];
                    exp_wr_pend = hv(vmode, exp_idx, prd);
                    exp_wr_data = hg(prd);
                    cur_idx     = exp_idx;
                    exp_idx     = (exp_idx == TC - 1) ? 32'd0 : exp_idx + 32'd1;
                    last_rd_addr = bus.mem_address;
                    last_rd_cyc  = cyc;
                    have_prev = 1; en_stable = 1; wrote = 0; stalls = 0;
                    rd_count++;
                end
                if (bus.mem_write && !wreq) begin
                    check_eq("wr_expected", 1, exp_wr_pend);
                    check_eq("wr_addr", bus.mem_address, cur_idx);
                    check_eq("wr_data", bus.mem_writedata, exp_wr_data);
                    if (bus.mem_address < TC) mem_m[bus.mem_address[1:0]] = bus.mem_writedata;
                    last_wr_addr = bus.mem_address;
                    exp_wr_pend = 0;
                    wrote = 1;
                    wr_count++;
                    stat_wr++;
                end
            end
            pv  = hv(vmode, bus.compute_address, bus.compute_read_state);
            pws = hg(bus.compute_read_state);
            @(posedge clk);
            #1;
            bus.mem_readdata        = prd;
            bus.compute_valid       = pv;
            bus.compute_write_state = pws;
        end
    end

    task automatic run_threads(input int n);
        int rc0 = rd_count;
        for (int i = 0; i < 400 * n && rd_count < rc0 + n; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("run_progress", rd_count >= rc0 + n, 1);
    endtask

    task automatic stop_run();
        enable = 1'b0;
        for (int i = 0; i < 200 && active; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("stop_idle", active, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0;
        int rc0;
        bit found;
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < TC; i++) mem_m[i] = rand128();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_mem_read", bus.mem_read, 0);
        check_eq("rst_mem_write", bus.mem_write, 0);
        check_eq("rst_sweep_done", sweep_done, 0);
        check_eq("rst_active", active, 0);
        check_eq("rst_mem_address", bus.mem_address, 0);
        check_eq("rst_compute_address", bus.compute_address, 0);
        check_eq("rst_compute_state", bus.compute_read_state, 0);
        check_eq("rst_writedata", bus.mem_writedata, 0);
        reset = 1'b0;

        // Two full sweeps, handler always valid, no stalls.
        vmode = 1; wmode = 0; enable = 1'b1;
        run_threads(9);
        check_eq("t1_sweeps", sweep_cnt, 2);
        check_eq("t1_writes", wr_count, 8);
        stop_run();
`ifdef DIRCC_SCHED_STATS_EN
        check_eq("stats_update_count", update_count, 9);
        check_eq("stats_sweep_count", sweep_count, 2);
`endif

        // Handler declines thread 2.
        vmode = 2; enable = 1'b1;
        run_threads(5);
        stop_run();

        // Fixed stalls: 3 cycles on reads, 2 on writes.
        vmode = 1; wmode = 2; enable = 1'b1;
        run_threads(4);
        stop_run();
        wmode = 0;

        // Drop enable while thread 1 is in COMPUTE.
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            rc0 = rd_count;
            @(negedge clk);
            #1;
            found = (rd_count > rc0) && (last_rd_addr == 32'd1);
        end
        check_eq("t4_found_thread1", found, 1);
        wc0 = wr_count;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        enable = 1'b0;
        for (int i = 0; i < 50 && active; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("t4_active", active, 0);
        check_eq("t4_wb_count", wr_count - wc0, 1);
        check_eq("t4_wb_addr", last_wr_addr, 1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("t4_idle_read", bus.mem_read, 0);
        end
        enable = 1'b1;
        run_threads(1);
        check_eq("t4_resume_addr", last_rd_addr, 2);

        // Reset while a write is stalled.
        wmode = 2;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #1;
            found = bus.mem_write;
        end
        check_eq("t5_found_write", found, 1);
        reset = 1'b1;
        #1;
        check_eq("t5_wr_drop", bus.mem_write, 0);
        check_eq("t5_rd_low", bus.mem_read, 0);
        check_eq("t5_active", active, 0);
        check_eq("t5_index", bus.mem_address, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check_eq("t5_writedata", bus.mem_writedata, 0);
        reset = 1'b0;
        run_threads(1);
        check_eq("t5_first_rd", last_rd_addr, 0);
        stop_run();

        // Random stalls and data-dependent handler.
        vmode = 0; wmode = 1; enable = 1'b1;
        run_threads(24);
        stop_run();
        wmode = 0;
`ifdef DIRCC_SCHED_STATS_EN
        check_eq("stats_update_final", update_count, stat_wr);
        check_eq("stats_sweep_final", sweep_count, stat_sw);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
